// File: rtl/id_ex_stage_if.sv
// Decode-to-execute bundle: D-side fields driven by decode, E-side fields returned by id_ex_stage.
interface id_ex_stage_if #(
    parameter int XLEN = 32
);
    logic            stallD, flushE, validD;
    logic            mem_to_regD, mem_writeD, reg_writeD, jumpD, jump_srcD;
    logic            alu_src_is_zeroD, hltD, branchD, inv_branchD;
    logic [2:0]      mem_sizeD;
    logic [1:0]      alu_srcAD, alu_srcBD;
    logic [3:0]      alu_controlD;
    logic [XLEN-1:0] pcD, rd1D, rd2D, immD;
    logic [4:0]      rs1D, rs2D, rdD;

    logic            mem_to_regE, mem_writeE, reg_writeE, jumpE, jump_srcE;
    logic            alu_src_is_zeroE, hltE, branchE, inv_branchE;
    logic [2:0]      mem_sizeE;
    logic [1:0]      alu_srcAE, alu_srcBE;
    logic [3:0]      alu_controlE;
    logic [XLEN-1:0] pcE, rd1E, rd2E, immE;
    logic [4:0]      rs1E, rs2E, rdE;
    logic            validE, freeze_front, halted;

    modport master (
        output stallD, flushE, validD, mem_to_regD, mem_writeD, reg_writeD, jumpD, jump_srcD,
               alu_src_is_zeroD, hltD, branchD, inv_branchD, mem_sizeD, alu_srcAD, alu_srcBD,
               alu_controlD, pcD, rd1D, rd2D, immD, rs1D, rs2D, rdD,
        input  mem_to_regE, mem_writeE, reg_writeE, jumpE, jump_srcE, alu_src_is_zeroE, hltE,
               branchE, inv_branchE, mem_sizeE, alu_srcAE, alu_srcBE, alu_controlE, pcE, rd1E,
               rd2E, immE, rs1E, rs2E, rdE, validE, freeze_front, halted
    );

    modport slave (
        input  stallD, flushE, validD, mem_to_regD, mem_writeD, reg_writeD, jumpD, jump_srcD,
               alu_src_is_zeroD, hltD, branchD, inv_branchD, mem_sizeD, alu_srcAD, alu_srcBD,
               alu_controlD, pcD, rd1D, rd2D, immD, rs1D, rs2D, rdD,
        output mem_to_regE, mem_writeE, reg_writeE, jumpE, jump_srcE, alu_src_is_zeroE, hltE,
               branchE, inv_branchE, mem_sizeE, alu_srcAE, alu_srcBE, alu_controlE, pcE, rd1E,
               rd2E, immE, rs1E, rs2E, rdE, validE, freeze_front, halted
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with stall/flush and the halt sequencer (RUN -> DRAIN -> HALTED).
// Optional bubble counter output enabled by defining ID_EX_BUBBLE_CNT_EN.
module id_ex_stage #(
    parameter int XLEN         = 32,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    id_ex_stage_if.slave       bus
`ifdef ID_EX_BUBBLE_CNT_EN
    ,
    output logic [31:0]        bubble_cnt
`endif
);
    localparam logic [1:0] S_RUN    = 2'd0;
    localparam logic [1:0] S_DRAIN  = 2'd1;
    localparam logic [1:0] S_HALTED = 2'd2;

    typedef struct packed {
        logic            mem_to_reg, mem_write, reg_write, jump, jump_src;
        logic            alu_src_is_zero, hlt, branch, inv_branch;
        logic [2:0]      mem_size;
        logic [1:0]      alu_srcA, alu_srcB;
        logic [3:0]      alu_control;
        logic [XLEN-1:0] pc, rd1, rd2, imm;
        logic [4:0]      rs1, rs2, rd;
        logic            valid;
    } ex_t;

    ex_t        d_bus, e_d, e_q;
    logic [1:0] state_d, state_q;
    logic [3:0] cnt_d, cnt_q;
    logic       freeze_d, freeze_q;
    logic       halted_d, halted_q;

    // Write-type controls are gated here so an invalid slot can never commit anything.
    always_comb begin
        d_bus                 = '0;
        d_bus.valid           = bus.validD;
        d_bus.mem_to_reg      = bus.mem_to_regD;
        d_bus.mem_write       = bus.mem_writeD & bus.validD;
        d_bus.reg_write       = bus.reg_writeD & bus.validD;
        d_bus.jump            = bus.jumpD & bus.validD;
        d_bus.jump_src        = bus.jump_srcD;
        d_bus.alu_src_is_zero = bus.alu_src_is_zeroD;
        d_bus.hlt             = bus.hltD & bus.validD;
        d_bus.branch          = bus.branchD & bus.validD;
        d_bus.inv_branch      = bus.inv_branchD;
        d_bus.mem_size        = bus.mem_sizeD;
        d_bus.alu_srcA        = bus.alu_srcAD;
        d_bus.alu_srcB        = bus.alu_srcBD;
        d_bus.alu_control     = bus.alu_controlD;
        d_bus.pc              = bus.pcD;
        d_bus.rd1             = bus.rd1D;
        d_bus.rd2             = bus.rd2D;
        d_bus.imm             = bus.immD;
        d_bus.rs1             = bus.rs1D;
        d_bus.rs2             = bus.rs2D;
        d_bus.rd              = bus.rdD;
    end

    always_comb begin
        e_d = d_bus;
        if (bus.flushE || (state_q != S_RUN)) e_d = '0;
        else if (bus.stallD)                  e_d = e_q;
    end

    // Halt sequencer: a flush or stall once draining has started never pauses or aborts it.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        freeze_d = freeze_q;
        halted_d = halted_q;
        case (state_q)
            S_RUN: begin
                if (e_q.valid && e_q.hlt && !bus.stallD) begin
                    state_d  = S_DRAIN;
                    cnt_d    = 4'(DRAIN_CYCLES - 1);
                    freeze_d = 1'b1;
                end
            end
            S_DRAIN: begin
                if (cnt_q == 4'd0) begin
                    state_d  = S_HALTED;
                    halted_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_HALTED: ;
            default:  state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q      <= '0;
            state_q  <= S_RUN;
            cnt_q    <= 4'd0;
            freeze_q <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            e_q      <= e_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            freeze_q <= freeze_d;
            halted_q <= halted_d;
        end
    end

`ifdef ID_EX_BUBBLE_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [31:0] bcnt_d, bcnt_q;
    logic        bubble_ev;

    // Only decode-originated bubbles count; halt-induced ones happen outside RUN.
    assign bubble_ev = (state_q == S_RUN) && (bus.flushE || (!bus.stallD && !bus.validD));

    always_comb begin
        bcnt_d = bcnt_q;
        if (bubble_ev) bcnt_d = sat_inc(bcnt_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bcnt_q <= 32'd0;
        else        bcnt_q <= bcnt_d;
    end

    assign bubble_cnt = bcnt_q;
`endif

    assign bus.mem_to_regE      = e_q.mem_to_reg;
    assign bus.mem_writeE       = e_q.mem_write;
    assign bus.reg_writeE       = e_q.reg_write;
    assign bus.jumpE            = e_q.jump;
    assign bus.jump_srcE        = e_q.jump_src;
    assign bus.alu_src_is_zeroE = e_q.alu_src_is_zero;
    assign bus.hltE             = e_q.hlt;
    assign bus.branchE          = e_q.branch;
    assign bus.inv_branchE      = e_q.inv_branch;
    assign bus.mem_sizeE        = e_q.mem_size;
    assign bus.alu_srcAE        = e_q.alu_srcA;
    assign bus.alu_srcBE        = e_q.alu_srcB;
    assign bus.alu_controlE     = e_q.alu_control;
    assign bus.pcE              = e_q.pc;
    assign bus.rd1E             = e_q.rd1;
    assign bus.rd2E             = e_q.rd2;
    assign bus.immE             = e_q.imm;
    assign bus.rs1E             = e_q.rs1;
    assign bus.rs2E             = e_q.rs2;
    assign bus.rdE              = e_q.rd;
    assign bus.validE           = e_q.valid;
    assign bus.freeze_front     = freeze_q;
    assign bus.halted           = halted_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage: reset, capture, stall/flush, invalid gating, halt sequence.
module tb_id_ex_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    id_ex_stage_if #(.XLEN(32)) bus ();

`ifdef ID_EX_BUBBLE_CNT_EN
    logic [31:0] bubble_cnt;
`endif

    id_ex_stage #(.XLEN(32), .DRAIN_CYCLES(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef ID_EX_BUBBLE_CNT_EN
        ,
        .bubble_cnt (bubble_cnt)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic [31:0] v);
        bus.stallD = 1'b0;           bus.flushE = 1'b0;
        bus.validD = v[0];           bus.mem_to_regD = v[0];
        bus.mem_writeD = v[0];       bus.reg_writeD = v[0];
        bus.jumpD = v[0];            bus.jump_srcD = v[0];
        bus.alu_src_is_zeroD = v[0]; bus.hltD = v[0];
        bus.branchD = v[0];          bus.inv_branchD = v[0];
        bus.mem_sizeD = v[2:0];      bus.alu_srcAD = v[1:0];
        bus.alu_srcBD = v[1:0];      bus.alu_controlD = v[3:0];
        bus.pcD = v;  bus.rd1D = v;  bus.rd2D = v;  bus.immD = v;
        bus.rs1D = v[4:0]; bus.rs2D = v[4:0]; bus.rdD = v[4:0];
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        set_d(32'hFFFF_FFFF);
        rst_n = 1'b0;
        tick();
        tick();
        n_checks++; if (bus.validE !== 1'b0) begin n_fail++; $display("FAIL reset_validE got %0b want 0", bus.validE); end
        n_checks++; if (bus.pcE !== 32'h0) begin n_fail++; $display("FAIL reset_pcE got %h want 0", bus.pcE); end
        n_checks++; if (bus.reg_writeE !== 1'b0) begin n_fail++; $display("FAIL reset_reg_writeE got %0b want 0", bus.reg_writeE); end
        n_checks++; if (bus.alu_controlE !== 4'h0) begin n_fail++; $display("FAIL reset_alu_controlE got %h want 0", bus.alu_controlE); end
        n_checks++; if (bus.rdE !== 5'h0) begin n_fail++; $display("FAIL reset_rdE got %h want 0", bus.rdE); end
        n_checks++; if (bus.immE !== 32'h0) begin n_fail++; $display("FAIL reset_immE got %h want 0", bus.immE); end
        n_checks++; if (bus.freeze_front !== 1'b0) begin n_fail++; $display("FAIL reset_freeze got %0b want 0", bus.freeze_front); end
        n_checks++; if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got %0b want 0", bus.halted); end
        rst_n = 1'b1;
        tick();
        n_checks++; if (bus.pcE !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL release_pcE got %h want ffffffff", bus.pcE); end
        n_checks++; if (bus.validE !== 1'b1) begin n_fail++; $display("FAIL release_validE got %0b want 1", bus.validE); end
        n_checks++; if (bus.rdE !== 5'h1F) begin n_fail++; $display("FAIL release_rdE got %h want 1f", bus.rdE); end
        // All-ones capture included a valid HLT; clear it before it starts a halt.
        set_d(32'h0);
        pulse_reset();
    endtask

    task automatic test_normal();
        set_d(32'h0);
        bus.validD = 1'b1; bus.pcD = 32'h100; bus.alu_controlD = 4'h3; bus.reg_writeD = 1'b1;
        tick();
        n_checks++; if (bus.pcE !== 32'h100) begin n_fail++; $display("FAIL normal_pcE got %h want 100", bus.pcE); end
        n_checks++; if (bus.alu_controlE !== 4'h3) begin n_fail++; $display("FAIL normal_alu got %h want 3", bus.alu_controlE); end
        n_checks++; if (bus.reg_writeE !== 1'b1) begin n_fail++; $display("FAIL normal_reg_writeE got %0b want 1", bus.reg_writeE); end
        n_checks++; if (bus.validE !== 1'b1) begin n_fail++; $display("FAIL normal_validE got %0b want 1", bus.validE); end
    endtask

    task automatic test_stall_flush();
        bus.stallD = 1'b1; bus.pcD = 32'h104;
        tick();
        n_checks++; if (bus.pcE !== 32'h100) begin n_fail++; $display("FAIL stall1_pcE got %h want 100", bus.pcE); end
        bus.pcD = 32'h108;
        tick();
        n_checks++; if (bus.pcE !== 32'h100) begin n_fail++; $display("FAIL stall2_pcE got %h want 100", bus.pcE); end
        n_checks++; if (bus.validE !== 1'b1) begin n_fail++; $display("FAIL stall2_validE got %0b want 1", bus.validE); end
        bus.flushE = 1'b1;
        tick();
        n_checks++; if (bus.validE !== 1'b0) begin n_fail++; $display("FAIL flush_validE got %0b want 0", bus.validE); end
        n_checks++; if (bus.reg_writeE !== 1'b0) begin n_fail++; $display("FAIL flush_reg_writeE got %0b want 0", bus.reg_writeE); end
        n_checks++; if (bus.pcE !== 32'h0) begin n_fail++; $display("FAIL flush_pcE got %h want 0", bus.pcE); end
        bus.flushE = 1'b0; bus.stallD = 1'b0;
    endtask

    task automatic test_invalid();
        set_d(32'h0);
        bus.reg_writeD = 1'b1; bus.mem_writeD = 1'b1; bus.jumpD = 1'b1; bus.pcD = 32'h200;
        tick();
        n_checks++; if (bus.reg_writeE !== 1'b0) begin n_fail++; $display("FAIL inv_reg_writeE got %0b want 0", bus.reg_writeE); end
        n_checks++; if (bus.mem_writeE !== 1'b0) begin n_fail++; $display("FAIL inv_mem_writeE got %0b want 0", bus.mem_writeE); end
        n_checks++; if (bus.jumpE !== 1'b0) begin n_fail++; $display("FAIL inv_jumpE got %0b want 0", bus.jumpE); end
        n_checks++; if (bus.validE !== 1'b0) begin n_fail++; $display("FAIL inv_validE got %0b want 0", bus.validE); end
        n_checks++; if (bus.pcE !== 32'h200) begin n_fail++; $display("FAIL inv_pcE got %h want 200", bus.pcE); end
    endtask

    task automatic test_halt();
        set_d(32'h0);
        bus.validD = 1'b1; bus.hltD = 1'b1; bus.pcD = 32'h300;
        tick();   // edge N: HLT in E
        n_checks++; if (bus.hltE !== 1'b1) begin n_fail++; $display("FAIL halt_hltE got %0b want 1", bus.hltE); end
        n_checks++; if (bus.freeze_front !== 1'b0) begin n_fail++; $display("FAIL halt_freezeN got %0b want 0", bus.freeze_front); end
        bus.hltD = 1'b0; bus.pcD = 32'h304;
        tick();   // N+1
        n_checks++; if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL halt_haltedN1 got %0b want 0", bus.halted); end
        bus.flushE = 1'b1;
        tick();   // N+2
        bus.flushE = 1'b0;
        n_checks++; if (bus.freeze_front !== 1'b1) begin n_fail++; $display("FAIL halt_freezeN2 got %0b want 1", bus.freeze_front); end
        n_checks++; if (bus.validE !== 1'b0) begin n_fail++; $display("FAIL halt_validE_drain got %0b want 0", bus.validE); end
        tick();   // N+3
        n_checks++; if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL halt_haltedN3 got %0b want 0", bus.halted); end
        tick();   // N+4
        n_checks++; if (bus.halted !== 1'b1) begin n_fail++; $display("FAIL halt_haltedN4 got %0b want 1", bus.halted); end
        n_checks++; if (bus.freeze_front !== 1'b1) begin n_fail++; $display("FAIL halt_freezeN4 got %0b want 1", bus.freeze_front); end
        n_checks++; if (bus.pcE !== 32'h0) begin n_fail++; $display("FAIL halt_pcE got %h want 0", bus.pcE); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL halt_reset_halted got %0b want 0", bus.halted); end
        n_checks++; if (bus.freeze_front !== 1'b0) begin n_fail++; $display("FAIL halt_reset_freeze got %0b want 0", bus.freeze_front); end
        rst_n = 1'b1;
        tick();
        n_checks++; if (bus.pcE !== 32'h304) begin n_fail++; $display("FAIL halt_resume_pcE got %h want 304", bus.pcE); end
    endtask

`ifdef ID_EX_BUBBLE_CNT_EN
    task automatic test_bubble_cnt();
        set_d(32'h0);
        pulse_reset();
        bus.validD = 1'b1; bus.flushE = 1'b1;
        tick();
        tick();
        bus.flushE = 1'b0; bus.validD = 1'b0;
        tick();
        bus.validD = 1'b1;
        tick();
        n_checks++; if (bubble_cnt !== 32'd3) begin n_fail++; $display("FAIL bcnt_three got %0d want 3", bubble_cnt); end
        bus.hltD = 1'b1;
        tick();
        bus.hltD = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        n_checks++; if (bus.halted !== 1'b1) begin n_fail++; $display("FAIL bcnt_halted got %0b want 1", bus.halted); end
        n_checks++; if (bubble_cnt !== 32'd3) begin n_fail++; $display("FAIL bcnt_after_halt got %0d want 3", bubble_cnt); end
    endtask
`endif

    initial begin
        set_d(32'h0);
        test_reset();
        test_normal();
        test_stall_flush();
        test_invalid();
        test_halt();
`ifdef ID_EX_BUBBLE_CNT_EN
        test_bubble_cnt();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register of the 5-stage RISC-V core; sits directly downstream of the decode controller.
- Captures the decoded control bundle and operand data each cycle, supports stall (hold) and flush (bubble insertion), and carries a valid bit.
- Owns the halt sequencer: once a valid HLT reaches execute, it freezes the front end, drains the back end for a fixed number of cycles, then raises a sticky halted flag.

Parameters:
- XLEN, 32, width of PC, register operands and immediate.
- DRAIN_CYCLES, 3, cycles allowed for EX/MEM/WB to retire after HLT enters execute; legal range 1..15.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- stallD  in  1  hold current E contents (hazard unit).
- flushE  in  1  replace next E contents with a bubble.
- validD  in  1  decode slot holds a real instruction.
- mem_to_regD, mem_writeD, reg_writeD, jumpD, jump_srcD, alu_src_is_zeroD, hltD, branchD, inv_branchD  in  1 each  controller outputs.
- mem_sizeD  in  3  load/store size code.
- alu_srcAD, alu_srcBD  in  2 each  ALU operand selects.
- alu_controlD  in  4  ALU opcode.
- pcD, rd1D, rd2D, immD  in  XLEN each  PC, register reads, immediate.
- rs1D, rs2D, rdD  in  5 each  register indices.
- Each D control/data input has a matching E-suffixed output of the same width (for example mem_writeE, alu_controlE, pcE, rdE).
- validE  out  1  E slot holds a real instruction.
- freeze_front  out  1  stall request to fetch/decode while halting.
- halted  out  1  sticky halt indication.

Behaviour:
- Reset (async, rst_n=0):
  - All E outputs, validE, freeze_front and halted go to 0.
  - FSM enters RUN; drain counter goes to 0.
  - Deassertion takes effect synchronously at the next clk edge.
- Capture priority on each posedge, highest first:
  1. Reset.
  2. Bubble, when flushE=1 or FSM is not RUN: all E outputs and validE are cleared to 0.
  3. Hold, when stallD=1: all registers keep their values.
  4. Otherwise E ← D, and validE ← validD.
- Flush beats stall when both are asserted in the same cycle.
- An invalid capture (validD=0) still loads the fields, but all write-type controls must be treated as inert downstream. The block itself gates them: reg_writeE, mem_writeE, jumpE, branchE and hltE load as 0 when validD=0.
- Latency: exactly 1 cycle from D to E. No combinational path from any D input to any E output.
- Halt FSM:
  - RUN: if validE=1, hltE=1 and stallD=0, go to DRAIN, load counter with DRAIN_CYCLES-1, and assert freeze_front (registered, visible the following cycle).
  - DRAIN: freeze_front=1, E captures bubbles, counter decrements each cycle. When the counter is 0, go to HALTED.
  - HALTED: freeze_front=1, halted=1, E holds a bubble. Leaves only on reset.
  - A flushE arriving in DRAIN or HALTED does not abort the halt.
  - A stallD arriving in DRAIN does not pause the counter.
  - If hltE is valid but stallD=1, the block stays in RUN until the stall clears.
- Counter is 4 bits; no wrap occurs within the legal parameter range.
- Reset mid-DRAIN or in HALTED returns to RUN with all outputs cleared.

Optional Feature:
- Macro: ID_EX_BUBBLE_CNT_EN.
- Enabled:
  - Adds output bubble_cnt (32 bits).
  - Increments on each posedge where a bubble is inserted by flushE while in RUN, or where validD=0 is captured with stallD=0.
  - Saturates at 0xFFFFFFFF and resets to 0.
  - Halt-induced bubbles are not counted.
- Disabled: port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 with all D inputs at 1 -> every E output, validE, freeze_front and halted read 0; release, one clean capture -> pcE=pcD.
- Normal flow: validD=1, pcD=0x100, alu_controlD=4'h3, reg_writeD=1 -> one cycle later pcE=0x100, alu_controlE=3, reg_writeE=1, validE=1.
- Stall then flush: stallD=1 for 2 cycles while pcD changes to 0x104, 0x108 -> pcE stays 0x100. Then stallD=1 with flushE=1 -> validE=0, reg_writeE=0, pcE=0.
- Invalid capture: validD=0, reg_writeD=1, mem_writeD=1 -> reg_writeE=0, mem_writeE=0, validE=0.
- Halt, DRAIN_CYCLES=3: valid hltD captured at cycle N -> freeze_front=1 at N+2, halted=1 at N+4. Flush pulse during DRAIN -> halted still at N+4. Then rst_n low -> halted=0.
- With ID_EX_BUBBLE_CNT_EN: 2 flushes plus 1 invalid capture -> bubble_cnt=3. Subsequent halt drain -> bubble_cnt stays 3.
